// File: rtl/fetch_queue_stage_pkg.sv
// fetch_queue_stage_pkg: FSM encoding, bubble default and width helper shared by the fetch stage
package fetch_queue_stage_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SQUASH} fetch_state_e;
  localparam logic [15:0] NOP_DEFAULT = 16'h0800;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// fetch_queue_stage_fifo: DEPTH-entry queue with sync flush and simultaneous push/pop
module fetch_queue_stage_fifo import fetch_queue_stage_pkg::*; #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  // pointers wrap naturally at the power-of-two depth; flush overrides everything
  always_comb begin
    wp_d = flush ? '0 : wp_q + AW'(push);
    rp_d = flush ? '0 : rp_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wp_q] <= din;
  end
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: fetch PC owner with single-outstanding imem reads feeding a decode queue
module fetch_queue_stage import fetch_queue_stage_pkg::*; #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter int               PC_STEP  = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP_INST = NOP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [WIDTH-1:0]      imem_addr,
  output logic                  imem_rd,
  input  logic [WIDTH-1:0]      imem_data,
  input  logic                  imem_done,
  input  logic                  redirect,
  input  logic [WIDTH-1:0]      redirect_pc,
  input  logic                  stall_f,
  input  logic                  halt_n,
  output logic [WIDTH-1:0]      inst,
  output logic [WIDTH-1:0]      pc_next,
  output logic                  inst_valid,
  output logic [clog2(DEPTH):0] count
);
  localparam int CW = clog2(DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d, pc_inc;
  logic rd_q, rd_d, push, pop, issue_ok, issue;
  logic [CW-1:0] cnt_post;
  logic [2*WIDTH-1:0] head;
  assign pc_inc = fetch_pc_q + WIDTH'(PC_STEP);
  fetch_queue_stage_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect),
    .push(push),
    .pop(pop),
    .din({imem_data, pc_inc}),
    .dout(head),
    .count(count)
  );
  // queue head to decode; a redirect hides the head in the cycle it flushes the queue
  always_comb begin
    inst_valid = count != '0 && !redirect;
    inst = inst_valid ? head[2*WIDTH-1:WIDTH] : NOP_INST;
    pc_next = inst_valid ? head[WIDTH-1:0] : '0;
    pop = inst_valid && !stall_f;
  end
  // fetch control: issue only with a free slot after this cycle's push/pop, so a response never overflows
  always_comb begin
    push = state_q == WAIT && imem_done && !redirect;
    cnt_post = count + CW'(push) - CW'(pop);
    issue_ok = halt_n && !redirect && cnt_post < CW'(DEPTH);
    state_d = state_q == IDLE ? (issue_ok ? WAIT : IDLE)
            : state_q == WAIT ? (redirect ? (imem_done ? IDLE : SQUASH)
                                          : imem_done ? (issue_ok ? WAIT : IDLE) : WAIT)
            : (imem_done ? IDLE : SQUASH);
    fetch_pc_d = redirect ? redirect_pc : push ? pc_inc : fetch_pc_q;
    issue = state_d == WAIT && (state_q == IDLE || imem_done);
    addr_d = issue ? fetch_pc_d : addr_q;
    rd_d = state_d != IDLE;
  end
  // registered FSM and memory request; address held separately so a squashed read keeps its old address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
    end
  end
  assign imem_addr = addr_q;
  assign imem_rd = rd_q;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: randomized scoreboard bench with a PC-sequence reference model
module tb_fetch_queue_stage;
  localparam int W = 16;
  localparam int D = 4;
  localparam logic [W-1:0] NOP = 16'h0800;
  typedef struct packed {
    logic [W-1:0] i;
    logic [W-1:0] p;
  } ent_t;
  logic clk = 0;
  logic rst = 1;
  logic [W-1:0] imem_addr, imem_data, redirect_pc, inst, pc_next;
  logic imem_rd, imem_done, redirect, stall_f, halt_n, inst_valid;
  logic [2:0] count;
  int total = 0;
  int bad = 0;
  ent_t exp_q[$];
  logic [W-1:0] model_pc = '0;
  bit stale = 0;
  bit live = 0;
  int lat = 0;
  int lat_max = 0;
  int p_stall = 0;
  int p_redir = 0;
  int p_halt = 0;

  fetch_queue_stage dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_rd(imem_rd),
    .imem_data(imem_data),
    .imem_done(imem_done),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .stall_f(stall_f),
    .halt_n(halt_n),
    .inst(inst),
    .pc_next(pc_next),
    .inst_valid(inst_valid),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic cycle();
    logic rd_s, done_s, red_s;
    logic [W-1:0] addr_s, rpc_s;
    @(negedge clk);
    stall_f = $urandom_range(99) < p_stall;
    halt_n = !($urandom_range(99) < p_halt);
    redirect = $urandom_range(99) < p_redir;
    case ($urandom_range(2))
      0: redirect_pc = 16'h0100;
      1: redirect_pc = 16'hFFFC;
      default: redirect_pc = W'($urandom) & 16'hFFFE;
    endcase
    imem_done = 0;
    if (imem_rd) begin
      if (lat == 0) begin
        imem_done = 1;
        lat = $urandom_range(lat_max);
      end else lat--;
    end
    imem_data = imem_addr ^ 16'hA5A5;
    rd_s = imem_rd;
    done_s = imem_done;
    red_s = redirect;
    addr_s = imem_addr;
    rpc_s = redirect_pc;
    @(posedge clk);
    #1;
    if (rd_s && done_s) begin
      if (!stale && !red_s) begin
        chk("imem_addr", addr_s, model_pc);
        exp_q.push_back(ent_t'{model_pc ^ 16'hA5A5, model_pc + W'(2)});
        model_pc = model_pc + W'(2);
      end
      stale = 0;
    end
    if (red_s) begin
      exp_q.delete();
      model_pc = rpc_s;
      if (rd_s && !done_s) stale = 1;
    end
  endtask

  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (live) begin
        chk("count", W'(count), W'(exp_q.size()));
        chk("inst_valid", W'(inst_valid), W'(exp_q.size() > 0 && !redirect));
        if (!inst_valid) chk("bubble", inst, NOP);
        else if (!stall_f) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop got=%h want=empty", inst);
          end else begin
            e = exp_q.pop_front();
            chk("inst", inst, e.i);
            chk("pc_next", pc_next, e.p);
          end
        end
      end
    end
  end

  initial begin
    {imem_done, redirect, stall_f, halt_n} = '0;
    imem_data = '0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst imem_rd", W'(imem_rd), '0);
    chk("rst imem_addr", imem_addr, '0);
    chk("rst inst", inst, NOP);
    chk("rst pc_next", pc_next, '0);
    chk("rst inst_valid", W'(inst_valid), '0);
    chk("rst count", W'(count), '0);
    @(negedge clk);
    rst = 0;
    live = 1;
    repeat (20) cycle();
    p_stall = 100;
    repeat (10) cycle();
    chk("full count", W'(count), W'(D));
    chk("full imem_rd", W'(imem_rd), '0);
    chk("full head", inst, exp_q.size() > 0 ? exp_q[0].i : NOP);
    p_stall = 0;
    repeat (8) cycle();
    lat_max = 3;
    p_stall = 30;
    p_redir = 5;
    p_halt = 10;
    repeat (2000) cycle();
    p_redir = 0;
    p_halt = 100;
    repeat (10) cycle();
    chk("halt imem_rd", W'(imem_rd), '0);
    p_stall = 0;
    repeat (10) cycle();
    chk("drain count", W'(count), '0);
    chk("drain model", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
